// File: rtl/inv_sqrt_seq.sv
// Vector reciprocal square root. One piecewise-linear LUT is shared by all lanes in
// turn; each lane yields a Q0.16 mantissa and a right-shift exponent (x^-0.5).

module inv_sqrt_lut (
    input  logic        clk,
    input  logic [6:0]  addr_i,
    output logic [15:0] slope_o,
    output logic [15:0] base_o
);
    // Smallest s with s^2 * (128 + a) >= 2^39, i.e. ceil(2^16 / sqrt(1 + a/128)).
    function automatic int ceil_isqrt(input int a);
        longint lo;
        longint hi;
        longint mid;
        lo = 0;
        hi = 65536;
        for (int k = 0; k < 17; k++) begin
            mid = (lo + hi) / 2;
            if (mid * mid * longint'(128 + a) >= 64'sh80_0000_0000) begin
                hi = mid;
            end else begin
                lo = mid;
            end
        end
        return int'(hi);
    endfunction

    logic [15:0] base_rom  [128];
    logic [15:0] slope_rom [128];

    // Slope is the (negative) step to the next segment's unclamped base.
    for (genvar gi = 0; gi < 128; gi++) begin : g_rom
        localparam int B0 = ceil_isqrt(gi);
        localparam int B1 = ceil_isqrt(gi + 1);
        assign base_rom[gi]  = (B0 > 65535) ? 16'hFFFF : 16'(B0);
        assign slope_rom[gi] = 16'(B1 - B0);
    end

    always_ff @(posedge clk) begin
        base_o  <= base_rom[addr_i];
        slope_o <= slope_rom[addr_i];
    end
endmodule

module inv_sqrt_seq #(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANES*16-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANES*16-1:0]  out_mant,
    output logic [LANES*4-1:0]   out_shift,
    output logic [LANES-1:0]     out_zero,
    output logic                 busy
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [15:0] RSQRT2 = 16'hB505;

    typedef enum logic [2:0] {IDLE, LOOK, INTERP, SCALE, DONE} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          accept;

    logic [LANES*16-1:0] data_q;
    logic [3:0]          msb_q;
    logic [7:0]          frac_q;
    logic                xzero_q;
    logic [15:0]         interp_q;

    logic [15:0]    mant_q  [LANES];
    logic [3:0]     shift_q [LANES];
    logic [LANES-1:0] zero_q;

    logic [15:0] lane_x [LANES];
    logic [15:0] cur_x;
    logic [3:0]  msb;
    logic [14:0] norm;

    logic [15:0] lut_slope;
    logic [15:0] lut_base;

    logic signed [24:0] slope_prod;
    logic signed [24:0] slope_term;
    logic signed [25:0] interp_sum;
    logic [15:0]        interp_sat;

    logic [15:0] mant_new;
    logic [3:0]  shift_new;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign lane_x[gi]              = data_q[gi*16 +: 16];
        assign out_mant[gi*16 +: 16]   = mant_q[gi];
        assign out_shift[gi*4 +: 4]    = shift_q[gi];
    end
    assign out_zero = zero_q;

    // Normalise the selected lane so its MSB sits at bit 15 (implicit, dropped).
    always_comb begin
        cur_x = lane_x[lane_q];
        msb   = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (cur_x[i]) begin
                msb = 4'(i);
            end
        end
        norm = 15'(cur_x << (4'd15 - msb));
    end

    inv_sqrt_lut u_lut (
        .clk     (clk),
        .addr_i  (norm[14:8]),
        .slope_o (lut_slope),
        .base_o  (lut_base)
    );

    always_comb begin
        slope_prod = $signed({{9{lut_slope[15]}}, lut_slope}) * $signed({17'd0, frac_q});
        slope_term = slope_prod >>> 8;
        interp_sum = $signed({10'd0, lut_base}) + $signed({slope_term[24], slope_term});
        if (interp_sum[25]) begin
            interp_sat = 16'h0000;
        end else if (|interp_sum[24:16]) begin
            interp_sat = 16'hFFFF;
        end else begin
            interp_sat = interp_sum[15:0];
        end
    end

    // Odd exponents fold the leftover 2^-0.5 into the mantissa.
    always_comb begin
        if (xzero_q) begin
            mant_new  = 16'hFFFF;
            shift_new = 4'd0;
        end else begin
            mant_new  = msb_q[0] ? 16'((32'(interp_q) * 32'(RSQRT2)) >> 16) : interp_q;
            shift_new = {1'b0, msb_q[3:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    lane_d  = '0;
                    state_d = LOOK;
                end
            end
            LOOK:   state_d = INTERP;
            INTERP: state_d = SCALE;
            SCALE: begin
                if (lane_q == LAST_LANE) begin
                    state_d = DONE;
                end else begin
                    lane_d  = lane_q + LW'(1);
                    state_d = LOOK;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lane_q   <= '0;
            data_q   <= '0;
            msb_q    <= '0;
            frac_q   <= '0;
            xzero_q  <= 1'b0;
            interp_q <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            if (accept) begin
                data_q <= in_data;
            end
            if (state_q == LOOK) begin
                msb_q   <= msb;
                frac_q  <= norm[7:0];
                xzero_q <= (cur_x == 16'd0);
            end
            if (state_q == INTERP) begin
                interp_q <= interp_sat;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++) begin
                mant_q[i]  <= '0;
                shift_q[i] <= '0;
            end
            zero_q <= '0;
        end else if (state_q == SCALE) begin
            mant_q[lane_q]  <= mant_new;
            shift_q[lane_q] <= shift_new;
            zero_q[lane_q]  <= xzero_q;
        end
    end
endmodule
